// File: rtl/mem_responder.sv
// Memory responder: accepts one word request, waits WAIT cycles, then answers with read data or an error.
// Optional MEM_RESPONDER_BYTE_WRITE_EN adds a req_be byte-lane mask for writes.
module mem_responder #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
   input  logic [3:0]  req_be,
`endif
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // a response transfers on a rising edge where rsp_valid && rsp_ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH];

   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic          acc_err;
   logic [AW-1:0] acc_idx;
   logic          enter_resp;
   logic          mem_we;
   logic [3:0]    in_be;

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
   assign in_be = req_be;
`else
   assign in_be = 4'hF;
`endif

   // With WAIT=0 the access happens on the accept edge, so it must use the live inputs.
   always_comb begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      if (state_q == S_IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = in_be;
      end
      acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
      acc_idx = acc_addr[AW+1:2];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = ~rst;
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = in_be;
               if (WAIT > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT);
               end else begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d    = S_RESP;
               cnt_d      = 4'd0;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_resp) begin
         err_d   = acc_err;
         rdata_d = (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
      end
   end

   assign mem_we    = enter_resp && acc_we && !acc_err;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is never reset; rst still blocks the write of an abandoned transaction.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, reset/hold/WAIT=0 sequences, randomized run against a word-array model.
`timescale 1ns/1ps
module tb_mem_responder;

   localparam int DEPTH = 64;
   localparam int WAITC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_be;
   logic [1:0]  dbg_state;

   logic        req_valid0, req_we0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
   logic [3:0]  req_be0;
   logic [1:0]  dbg_state0;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];
   logic [31:0] model_mem [DEPTH];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          hold;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(DEPTH), .WAIT(WAITC)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
      .req_be(req_be),
`endif
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
   );

   mem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_we(req_we0),
      .req_addr(req_addr0), .req_wdata(req_wdata0),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
      .req_be(req_be0),
`endif
      .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .dbg_state(dbg_state0)
   );

   initial begin
      #400us;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One full transaction on the WAIT=2 instance; hold = cycles rsp_ready stays low in RESP.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold,
                      output int lat, output logic err, output logic [31:0] rdata);
      int n;
      lat = 0; err = 1'bx; rdata = 'x;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_be = 4'($urandom);
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      if (!rsp_valid) begin
         chk("response_timeout", 32'd0, 32'd1);
         return;
      end
      err = rsp_err; rdata = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = $urandom; req_be = 4'hF;
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", rsp_rdata, rdata);
         chk("hold_err", 32'(rsp_err), 32'(err));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata);
      @(negedge clk);
      chk("w0_req_ready", 32'(req_ready0), 32'd1);
      req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_be0 = 4'hF;
      @(posedge clk);
      #1;
      req_valid0 = 1'b0; req_addr0 = $urandom; req_wdata0 = $urandom; req_we0 = 1'($urandom);
      @(negedge clk);
      chk("w0_lat1_valid", 32'(rsp_valid0), 32'd1);
      chk("w0_rdata", rsp_rdata0, exp_rdata);
      chk("w0_err", 32'(rsp_err0), 32'(exp_err));
      rsp_ready0 = 1'b1;
      @(posedge clk);
      #1 rsp_ready0 = 1'b0;
      @(negedge clk);
      chk("w0_post_valid", 32'(rsp_valid0), 32'd0);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] r;
      r = old;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
`else
      r = nw;
      if (be == 4'h0) r = nw;
`endif
      return r;
   endfunction

   // Reference: misaligned or beyond DEPTH words errors; writes answer 0; reads answer the model word.
   task automatic scored(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold);
      logic        bad, err;
      logic [31:0] rdata;
      logic [32:0] exp;
      int          lat;
      bad = (addr % 4 != 0) || (longint'(addr) >= longint'(DEPTH) * 4);
      if (bad) exp = {1'b1, 32'h0};
      else if (we) begin
         exp = {1'b0, 32'h0};
         model_mem[addr / 4] = merge(model_mem[addr / 4], wdata, be);
      end else exp = {1'b0, model_mem[addr / 4]};
      exp_q.push_back(exp);
      txn(we, addr, wdata, be, hold, lat, err, rdata);
      exp = exp_q.pop_front();
      chk("rand_latency", 32'(lat), 32'(WAITC + 1));
      chk("rand_err", 32'(err), 32'(exp[32]));
      chk("rand_rdata", rdata, exp[31:0]);
   endtask

   initial begin
      int          lat;
      logic        err;
      logic [31:0] rdata, addr;
      int          sel, idx;

      rst = 1'b1;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 4'hF; rsp_ready = 0;
      req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 4'hF; rsp_ready0 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rdata", rsp_rdata, 32'h0);
      chk("reset_err", 32'(rsp_err), 32'd0);
      chk("reset_rsp_valid0", 32'(rsp_valid0), 32'd0);
      rst = 1'b0;
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_req_ready0", 32'(req_ready0), 32'd1);

      vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h10,  32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 32'h13,  32'h0,        4'hF, 0, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 32'h100, 32'h0,        4'hF, 0, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 32'h10,  32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 32'h04,  32'hCAFEF00D, 4'hF, 0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h104, 32'h12345678, 4'hF, 0, 1'b1, 32'h0});
      vecs.push_back('{1'b1, 32'h06,  32'h87654321, 4'hF, 1, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 32'h04,  32'h0,        4'hF, 0, 1'b0, 32'hCAFEF00D});
      vecs.push_back('{1'b1, 32'hFC,  32'hA5A5A5A5, 4'hF, 2, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'hFC,  32'h0,        4'hF, 0, 1'b0, 32'hA5A5A5A5});
      vecs.push_back('{1'b0, 32'h10,  32'h0,        4'hF, 5, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 32'h10,  32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 32'h20,  32'h11111111, 4'hF, 0, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h20,  32'h0,        4'hF, 0, 1'b0, 32'h11111111});
      for (int i = 0; i < vecs.size(); i++) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, lat, err, rdata);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAITC + 1));
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      end

      // Reset in the middle of the wait phase of a write must drop it.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h99999999; req_be = 4'hF;
      chk("rstwait_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstwait_in_wait", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      #1;
      chk("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstwait_rdata", rsp_rdata, 32'h0);
      chk("rstwait_err", 32'(rsp_err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rstwait_req_ready_after", 32'(req_ready), 32'd1);
      txn(1'b0, 32'h20, 32'h0, 4'hF, 0, lat, err, rdata);
      chk("rstwait_read_rdata", rdata, 32'h11111111);
      chk("rstwait_read_err", 32'(err), 32'd0);

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
      txn(1'b1, 32'h30, 32'hAABBCCDD, 4'hF, 0, lat, err, rdata);
      txn(1'b1, 32'h30, 32'h11223344, 4'b0101, 0, lat, err, rdata);
      txn(1'b0, 32'h30, 32'h0, 4'hF, 0, lat, err, rdata);
      chk("be_merge_rdata", rdata, 32'hAA22CC44);
      txn(1'b1, 32'h30, 32'h55555555, 4'b0000, 0, lat, err, rdata);
      chk("be_zero_err", 32'(err), 32'd0);
      txn(1'b0, 32'h30, 32'h0, 4'hF, 0, lat, err, rdata);
      chk("be_zero_rdata", rdata, 32'hAA22CC44);
`endif

      txn0(1'b1, 32'h08, 32'h5A5A0001, 1'b0, 32'h0);
      txn0(1'b0, 32'h08, 32'h0,        1'b0, 32'h5A5A0001);
      txn0(1'b0, 32'h09, 32'h0,        1'b1, 32'h0);
      txn0(1'b1, 32'h200, 32'h77777777, 1'b1, 32'h0);
      txn0(1'b0, 32'h08, 32'h0,        1'b0, 32'h5A5A0001);

      for (int i = 0; i < DEPTH; i++) scored(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
      for (int t = 0; t < 150; t++) begin
         sel = $urandom_range(0, 9);
         idx = $urandom_range(0, DEPTH - 1);
         if (sel < 7)       addr = 32'(idx * 4);
         else if (sel == 7) addr = 32'(idx * 4 + $urandom_range(1, 3));
         else if (sel == 8) addr = 32'(idx * 4) | (32'h1 << $urandom_range(8, 31));
         else               addr = $urandom;
         scored(1'($urandom), addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the internal memory; a power of two, 4..1024.
REQ-002 Parameter WAIT, default 2: wait cycles between request acceptance and memory access; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  processor presents a memory request.
REQ-006 req_we  input  1  1 = write, 0 = read (the processor's MemWrite).
REQ-007 req_addr  input  32  byte address, selected upstream by IorD between PC and ALUOut.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  responder accepts a request this cycle.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  processor consumes the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  the request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 IDLE: req_ready=1; on req_valid=1, capture req_we/addr/wdata; go to WAIT if WAIT>0, else to RESP.
REQ-016 WAIT: req_ready=0; the 4-bit counter loaded with WAIT at acceptance decrements each cycle; on the cycle it reaches 1, go to RESP.
REQ-017 The memory access SHALL occur on the clock edge that enters RESP; this is the only edge that can write memory.
REQ-018 RESP: rsp_valid=1 and req_ready=0; rsp_rdata/rsp_err stay stable until rsp_ready=1, then go to IDLE.
REQ-019 Latency: a request accepted at edge N SHALL have rsp_valid=1 after edge N+WAIT+1.
REQ-020 Back-to-back rate: one request per WAIT+2 cycles minimum; after the response handshake, one IDLE cycle precedes the next acceptance.
REQ-021 Word index = req_addr[log2(DEPTH)+1:2].
REQ-022 Error when req_addr[1:0]!=0 or req_addr[31:log2(DEPTH)+2]!=0: rsp_err=1, rsp_rdata=0, memory not modified.
REQ-023 Valid read: rsp_rdata = mem[index], rsp_err=0.
REQ-024 Valid write: mem[index] <= captured wdata, rsp_rdata=0, rsp_err=0.
REQ-025 Inputs changing after acceptance SHALL not affect the pending transaction.
REQ-026 Reading an address written earlier SHALL return the written data; there is no forwarding requirement within one transaction.

Reset
REQ-027 On rst=1: state=IDLE, counter=0, req_ready=1 while rst is low again and idle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 Reset during WAIT or RESP SHALL abandon the transaction; a pending write SHALL not reach memory.
REQ-029 Memory contents are not reset and are undefined until written.

Configuration
REQ-030 Macro MEM_RESPONDER_BYTE_WRITE_EN defined: adds input req_be[3:0]; a valid write updates only byte lanes whose bit is 1 (bit0 = bits 7:0); req_be=0 writes nothing but still responds.
REQ-031 Macro undefined: no req_be port; every valid write updates all 32 bits.

Verification
REQ-032 WAIT=2: write addr 0x10, data 0xDEADBEEF; then read 0x10 -> rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-033 Read addr 0x13 (misaligned) and 0x100 (DEPTH=64, out of range) -> rsp_err=1, rdata=0; a later read of 0x10 still returns 0xDEADBEEF.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
REQ-035 Assert rst for 1 cycle during WAIT of a write to 0x20 (previously 0x11111111) -> outputs reset; a later read of 0x20 returns 0x11111111.
REQ-036 WAIT=0: accept a read at edge N -> rsp_valid at N+1.
REQ-037 With the macro defined: write 0xAABBCCDD to 0x30, then 0x11223344 with req_be=4'b0101 -> read returns 0xAA22CC44.
